// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder: master drives operands and
// out_ready, slave returns in_ready and the registered result.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             c0;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sout;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, in1, in2, c0, sub, out_ready,
        input  in_ready, out_valid, sout, cout, ovf
    );

    modport slave (
        input  in_valid, in1, in2, c0, sub, out_ready,
        output in_ready, out_valid, sout, cout, ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// Segmented pipelined adder: STAGES stages each add one WIDTH/STAGES slice with
// rippled 4-bit CLA groups. Define PIPE_ADDER_SUB_EN to honour the sub input.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic         clk,
    input logic         rst_n,
    pipe_adder_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH / 4 || (WIDTH % (4 * STAGES)) != 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of 4*STAGES with 1 <= STAGES <= WIDTH/4");
    end

    // Returns {carry out of bit 3, carry into bit 3, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], c[3], p ^ c[3:0]};
    endfunction

    // Returns {segment carry out, carry into segment MSB, segment sum}.
    function automatic logic [SEG+1:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                               input logic ci);
        logic [SEG-1:0] s;
        logic           c;
        logic           cm;
        logic [5:0]     r;
        s  = '0;
        c  = ci;
        cm = ci;
        for (int g = 0; g < SEG / 4; g++) begin
            r          = cla4(a[4*g +: 4], b[4*g +: 4], c);
            s[4*g +: 4] = r[3:0];
            cm         = r[4];
            c          = r[5];
        end
        return {c, cm, s};
    endfunction

    logic             adv;
    logic [WIDTH-1:0] op_b;
    logic             op_c;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

`ifdef PIPE_ADDER_SUB_EN
    assign op_b = bus.sub ? ~bus.in2 : bus.in2;
    assign op_c = bus.c0 ^ bus.sub;
`else
    logic unused_sub;
    assign unused_sub = bus.sub;
    assign op_b       = bus.in2;
    assign op_c       = bus.c0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int HI = LO + SEG;

        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                c_in;
        logic                v_in;
        logic [SEG+1:0]      add;
        logic [HI-1:0]       s_nxt;
        logic [HI-1:0]       s_p;
        logic                c_p;
        logic                vld_p;

        assign add = seg_add(a_in[SEG-1:0], b_in[SEG-1:0], c_in);

        if (k == 0) begin : g_src
            assign a_in  = bus.in1;
            assign b_in  = op_b;
            assign c_in  = op_c;
            assign v_in  = bus.in_valid;
            assign s_nxt = add[SEG-1:0];
        end else begin : g_src
            // Only the registered carry of the previous slice crosses the boundary.
            assign a_in  = g_stg[k-1].g_op.a_p;
            assign b_in  = g_stg[k-1].g_op.b_p;
            assign c_in  = g_stg[k-1].c_p;
            assign v_in  = g_stg[k-1].vld_p;
            assign s_nxt = {add[SEG-1:0], g_stg[k-1].s_p};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
            end else if (adv) begin
                vld_p <= v_in;
            end
        end

        if (k < STAGES - 1) begin : g_op
            logic [WIDTH-HI-1:0] a_p;
            logic [WIDTH-HI-1:0] b_p;
            logic                unused_cm;
            assign unused_cm = add[SEG];

            // ---- stage boundary: slice k summed, upper slices carried forward
            always_ff @(posedge clk) begin
                if (adv) begin
                    s_p <= s_nxt;
                    c_p <= add[SEG+1];
                    a_p <= a_in[WIDTH-LO-1:SEG];
                    b_p <= b_in[WIDTH-LO-1:SEG];
                end
            end
        end else begin : g_out
            logic ovf_p;

            // ---- output boundary: full sum, carry and overflow registered
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_p   <= '0;
                    c_p   <= 1'b0;
                    ovf_p <= 1'b0;
                end else if (adv) begin
                    s_p   <= s_nxt;
                    c_p   <= add[SEG+1];
                    ovf_p <= add[SEG+1] ^ add[SEG];
                end
            end
        end
    end

    assign bus.out_valid = g_stg[STAGES-1].vld_p;
    assign bus.sout      = g_stg[STAGES-1].s_p;
    assign bus.cout      = g_stg[STAGES-1].c_p;
    assign bus.ovf       = g_stg[STAGES-1].g_out.ovf_p;
endmodule

// File: tb/tb_pipe_adder.sv
// Directed and randomized bench for pipe_adder (WIDTH=32, STAGES=2) with an
// arithmetic reference model and a result queue.
module tb_pipe_adder;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int LAT    = STAGES - 1;
`ifdef PIPE_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif
    localparam logic [31:0] SUB_EXP = SUB_EN ? 32'hFFFF_FFFE : 32'h0000_000C;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(WIDTH)) bus ();

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [33:0] expq[$];

    // {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic c, input logic s);
        logic [31:0] bb;
        logic        cc;
        logic [32:0] t;
        logic        v;
        bb = b;
        cc = c;
        if (SUB_EN && s) begin
            bb = ~b;
            cc = ~c;
        end
        t = {1'b0, a} + {1'b0, bb} + {32'd0, cc};
        v = (a[31] == bb[31]) && (t[31] != a[31]);
        return {v, t};
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s, input logic ordy);
        bus.in_valid  = v;
        bus.in1       = a;
        bus.in2       = b;
        bus.c0        = c;
        bus.sub       = s;
        bus.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Account for the transfers that the coming edge will perform.
    task automatic score(input string tag);
        logic [33:0] e;
        if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                chk({tag, "_extra"}, 34'(bus.out_valid), 34'd0);
            end else begin
                e = expq.pop_front();
                chk(tag, {bus.ovf, bus.cout, bus.sout}, e);
            end
        end
        if (bus.in_valid && bus.in_ready)
            expq.push_back(ref_add(bus.in1, bus.in2, bus.c0, bus.sub));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        while (expq.size() != 0 && n < 20) begin
            #1;
            score(tag);
            step();
            n++;
        end
        chk({tag, "_left"}, 34'(expq.size()), 34'd0);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_idle"}, 34'(bus.out_valid), 34'd0);
            step();
        end
    endtask

    // One bundle into an idle pipe; result must appear exactly LAT edges after acceptance.
    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s, input logic [31:0] es,
                          input logic ec, input logic eo);
        drive(1'b1, a, b, c, s, 1'b1);
        #1;
        chk({tag, "_in_ready"}, 34'(bus.in_ready), 34'd1);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < LAT; i++) begin
            chk({tag, "_early"}, 34'(bus.out_valid), 34'd0);
            step();
        end
        chk({tag, "_valid"}, 34'(bus.out_valid), 34'd1);
        chk({tag, "_sout"}, 34'(bus.sout), 34'(es));
        chk({tag, "_cout"}, 34'(bus.cout), 34'(ec));
        chk({tag, "_ovf"}, 34'(bus.ovf), 34'(eo));
        step();
        chk({tag, "_once"}, 34'(bus.out_valid), 34'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] held;
        int          n;

        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        #12;
        chk("rst_out_valid", 34'(bus.out_valid), 34'd0);
        chk("rst_in_ready", 34'(bus.in_ready), 34'd1);
        chk("rst_sout", 34'(bus.sout), 34'd0);
        chk("rst_cout", 34'(bus.cout), 34'd0);
        chk("rst_ovf", 34'(bus.ovf), 34'd0);
        @(negedge clk);
        rst_n = 1'b1;

        single("seg_carry", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
        single("wrap_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        single("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        single("sub", 32'd5, 32'd7, 1'b0, 1'b1, SUB_EXP, 1'b0, 1'b0);

        for (int j = 0; j <= 10 + LAT; j++) begin
            if (j < 10) drive(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b1);
            else        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            #1;
            chk("b2b_in_ready", 34'(bus.in_ready), 34'd1);
            chk("b2b_out_valid", 34'(bus.out_valid), 34'((j >= LAT + 1) && (j <= 10 + LAT)));
            score("b2b_result");
            step();
        end
        drain("b2b_drain");

        n = 0;
        do begin
            drive(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b0);
            #1;
            score("stall_fill");
            step();
            n++;
        end while (!bus.out_valid && n < 8);
        chk("stall_fill_valid", 34'(bus.out_valid), 34'd1);
        held = bus.sout;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'b0);
            #1;
            chk("stall_in_ready", 34'(bus.in_ready), 34'd0);
            chk("stall_valid", 34'(bus.out_valid), 34'd1);
            chk("stall_sout", 34'(bus.sout), 34'(held));
            score("stall");
            step();
        end
        drain("stall_drain");

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) != 0));
            #1;
            chk("rnd_in_ready", 34'(bus.in_ready), 34'(!bus.out_valid || bus.out_ready));
            score("rnd_result");
            step();
        end
        drain("rnd_drain");

        drive(1'b1, rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, rnd_op(), rnd_op(), 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("flight_valid", 34'(bus.out_valid), 34'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 34'(bus.out_valid), 34'd0);
        chk("midrst_in_ready", 34'(bus.in_ready), 34'd1);
        chk("midrst_sout", 34'(bus.sout), 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expq.delete();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_stale", 34'(bus.out_valid), 34'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
